gppcu_stall_gen: RTL and testbench
==================================

# gppcu_stall_gen

Register scoreboard for the GPPCU decode stage. It tracks which registers have a write in flight between decode and writeback. It drives a single enable that lets the decode-stage instruction proceed only when none of its operand or destination registers is pending. It sits in the shared pipeline control of the core, once for all threads, between the instruction decoder and the thread array.

## Interface
Parameters:
- NUMREG, 32, number of tracked registers.
- RBW, $clog2(NUMREG) (5), register index width; derived, not overridden.

Ports:
- iACLK  in  1  single clock; all state updates on the rising edge.
- inRST  in  1  reset, asynchronous and active-high, keeping the codebase name.
- iREGD  in  RBW  destination register of the decode-stage instruction.
- iREGA  in  RBW  source A register of the decode-stage instruction.
- iREGB  in  RBW  source B register of the decode-stage instruction.
- iVALID_REGD  in  1  decode slot is valid and writes iREGD.
- iVALID_REGA  in  1  decode slot is valid and reads iREGA.
- iVALID_REGB  in  1  decode slot is valid and reads iREGB.
- oENABLED  out  1  decode instruction may issue this cycle; combinational.
- iWRREG  in  RBW  register being written back this cycle.
- iWRREG_VALID  in  1  writeback of iWRREG occurs this cycle.

## Operation
- State: pending vector P[NUMREG-1:0]. P[r]=1 means an issued instruction will write r and has not yet reached writeback.
- Effective pending: E[r] = P[r] & ~(iWRREG_VALID & iWRREG==r). A register written back this cycle counts as available, because the register file writes through.
- oENABLED = ~(iVALID_REGA & E[iREGA]) & ~(iVALID_REGB & E[iREGB]) & ~(iVALID_REGD & E[iREGD]). This covers RAW on both sources and WAW on the destination.
- With no valid flags asserted, oENABLED=1.
- Issue = oENABLED & iVALID_REGD. It sets P[iREGD] on the next edge.
- Writeback: iWRREG_VALID clears P[iWRREG] on the next edge.
- Same register set and cleared in the same cycle: the set wins, because the new writer is now pending.
- Different registers set and cleared in the same cycle: both updates apply.
- All registers, including r0, are tracked uniformly with no hard-wired zero register.
- Out-of-range indices (index ≥ NUMREG when NUMREG is not a power of 2) are never pending. They are ignored for set and clear.
- Contract with the core: whenever oENABLED=1 with iVALID_REGD=1, the decode slot advances on that edge. A slot held after issue would self-block on its own destination.

## Timing
- Reset (inRST=1, asynchronous): P=0 immediately, so oENABLED=1 regardless of inputs while in reset.
- Reset mid-operation: all pending writes are discarded. Writebacks arriving after reset release are harmless clears.
- oENABLED has zero latency from the inputs (combinational through P, iWRREG and iWRREG_VALID).
- A set or clear becomes visible in P one cycle after the edge.
- A dependent instruction that enters decode the cycle after its producer issues sees a stall. The stall lasts until the cycle the producer is in writeback, and the consumer is enabled in that cycle by the bypass.
- F-D-E-W pipeline: a back-to-back dependency therefore stalls decode exactly 1 cycle.

## Structure
- Shared package (GPPCU_PARAMETERS): register-field offsets INSTR_REGD_5, INSTR_REGA_5 and INSTR_REGB_5; control-word bits CW_REGWR, CW_USEREGA and CW_USEREGB. The core derives this block's inputs from these.
- No sub-module: one flop vector plus compare and mux logic. The per-register next-state may be written as a generate loop.

## Test plan
- Reset: assert inRST with random inputs -> oENABLED=1. After release, P=0.
- RAW stall: cycle 0 issue REGD=2 (VALID_REGD=1, oENABLED=1). Cycle 1 REGA=2 valid -> oENABLED=0. Cycle 2 with iWRREG=2 valid -> oENABLED=1. Cycle 3 P[2]=0.
- WAW: r5 pending, decode writes r5 with no sources -> oENABLED=0 until writeback of r5.
- Independent regs: r3 pending, decode reads r1/r4 and writes r6 -> oENABLED=1. P[6] sets next cycle.
- Simultaneous set/clear r7 (writeback r7 while issuing a new write to r7) -> oENABLED=1. P[7]=1 afterward.
- Invalid flags: r1 pending, REGA=1 with iVALID_REGA=0 -> oENABLED=1. Async reset mid-stall -> oENABLED rises without a clock edge.

Source files
------------

// File: rtl/gppcu_stall_gen_pkg.sv
// GPPCU shared parameters: register count, instruction register-field
// offsets and control-word bits from which the stall generator is fed.
package gppcu_stall_gen_pkg;

  localparam int GPPCU_NUMREG = 32;

  localparam int INSTR_REGD_5 = 21;
  localparam int INSTR_REGA_5 = 16;
  localparam int INSTR_REGB_5 = 11;

  localparam int CW_REGWR   = 0;
  localparam int CW_USEREGA = 1;
  localparam int CW_USEREGB = 2;

  typedef struct packed {
    logic [4:0] regd;
    logic [4:0] rega;
    logic [4:0] regb;
    logic       use_d;
    logic       use_a;
    logic       use_b;
  } dec_regs_t;

endpackage

// File: rtl/gppcu_stall_gen.sv
// Register scoreboard: tracks in-flight writes and gates decode issue
// on RAW (sources) and WAW (destination) hazards, with writeback bypass.
module gppcu_stall_gen
  import gppcu_stall_gen_pkg::*;
#(
  parameter  int NUMREG = GPPCU_NUMREG,
  localparam int RBW    = $clog2(NUMREG)
) (
  input  logic           iACLK,
  input  logic           inRST,
  input  logic [RBW-1:0] iREGD,
  input  logic [RBW-1:0] iREGA,
  input  logic [RBW-1:0] iREGB,
  input  logic           iVALID_REGD,
  input  logic           iVALID_REGA,
  input  logic           iVALID_REGB,
  output logic           oENABLED,
  input  logic [RBW-1:0] iWRREG,
  input  logic           iWRREG_VALID
);

  logic [NUMREG-1:0] pend;
  logic [NUMREG-1:0] wb_hit;
  logic [NUMREG-1:0] eff;
  logic [NUMREG-1:0] sel_d;
  logic [NUMREG-1:0] sel_a;
  logic [NUMREG-1:0] sel_b;
  logic [NUMREG-1:0] set_hit;
  logic [NUMREG-1:0] nxt;
  logic              busy_a;
  logic              busy_b;
  logic              busy_d;
  logic              issue;

  // Indices >= NUMREG match no bit, so they are never pending or updated
  for (genvar r = 0; r < NUMREG; r++) begin : g_sel
    assign sel_d[r]  = iREGD == RBW'(r);
    assign sel_a[r]  = iREGA == RBW'(r);
    assign sel_b[r]  = iREGB == RBW'(r);
    assign wb_hit[r] = iWRREG_VALID && (iWRREG == RBW'(r));
  end

  assign eff    = pend & ~wb_hit;
  assign busy_a = iVALID_REGA && |(eff & sel_a);
  assign busy_b = iVALID_REGB && |(eff & sel_b);
  assign busy_d = iVALID_REGD && |(eff & sel_d);

  assign oENABLED = ~busy_a & ~busy_b & ~busy_d;
  assign issue    = oENABLED & iVALID_REGD;
  assign set_hit  = issue ? sel_d : '0;

  // Set after clear: a new writer of the retiring register stays pending
  assign nxt = (pend & ~wb_hit) | set_hit;

  always_ff @(posedge iACLK or posedge inRST) begin
    if (inRST) pend <= '0;
    else       pend <= nxt;
  end

endmodule

// File: tb/tb_gppcu_stall_gen.sv
// Scoreboard bench for gppcu_stall_gen: directed decode/writeback
// vectors with hand-computed enable and pending-vector expectations.
module tb_gppcu_stall_gen;

  logic       clk;
  logic       rst;
  logic [4:0] regd, rega, regb, wrreg;
  logic       vd, va, vb, wv;
  logic       en;

  int checks;
  int errors;
  bit drv_done;

  typedef struct {
    string       nm;
    logic        en;
    logic [31:0] p;
  } exp_t;

  exp_t sbq[$];

  gppcu_stall_gen #(.NUMREG(32)) dut (
    .iACLK(clk),
    .inRST(rst),
    .iREGD(regd),
    .iREGA(rega),
    .iREGB(regb),
    .iVALID_REGD(vd),
    .iVALID_REGA(va),
    .iVALID_REGB(vb),
    .oENABLED(en),
    .iWRREG(wrreg),
    .iWRREG_VALID(wv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] d, input logic [4:0] a,
                       input logic [4:0] b, input logic fd,
                       input logic fa, input logic fb,
                       input logic [4:0] w, input logic fw);
    regd = d; rega = a; regb = b;
    vd = fd; va = fa; vb = fb;
    wrreg = w; wv = fw;
  endtask

  task automatic push(input string nm, input logic e,
                      input logic [31:0] p);
    exp_t x;
    x.nm = nm; x.en = e; x.p = p;
    sbq.push_back(x);
  endtask

  // One decode cycle: inputs change just after the edge, check at negedge
  task automatic cyc(input string nm,
                     input logic [4:0] d, input logic [4:0] a,
                     input logic [4:0] b, input logic fd,
                     input logic fa, input logic fb,
                     input logic [4:0] w, input logic fw,
                     input logic e, input logic [31:0] p);
    @(posedge clk); #1;
    drive(d, a, b, fd, fa, fb, w, fw);
    push(nm, e, p);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        x = sbq.pop_front();
        checks++;
        if (en !== x.en) begin
          errors++;
          $display("FAIL %s en: got %b want %b", x.nm, en, x.en);
        end
        checks++;
        if (dut.pend !== x.p) begin
          errors++;
          $display("FAIL %s pend: got %h want %h", x.nm, dut.pend, x.p);
        end
      end
    end
  end

  initial begin : driver
    checks = 0; errors = 0; drv_done = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom));
      push("rst_rand", 1'b1, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push("idle", 1'b1, 32'h0);

    cyc("raw_issue",  2, 0, 0, 1, 0, 0, 0, 0, 1'b1, 32'h0);
    cyc("raw_stall",  0, 2, 0, 0, 1, 0, 0, 0, 1'b0, 32'h4);
    cyc("raw_bypass", 0, 2, 0, 0, 1, 0, 2, 1, 1'b1, 32'h4);
    cyc("raw_clear",  0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0);

    cyc("waw_issue",  5, 0, 0, 1, 0, 0, 0, 0, 1'b1, 32'h0);
    cyc("waw_stall1", 5, 0, 0, 1, 0, 0, 0, 0, 1'b0, 32'h20);
    cyc("waw_stall2", 5, 0, 0, 1, 0, 0, 0, 0, 1'b0, 32'h20);
    cyc("waw_bypass", 5, 0, 0, 1, 0, 0, 5, 1, 1'b1, 32'h20);
    cyc("waw_repend", 0, 0, 0, 0, 0, 0, 5, 1, 1'b1, 32'h20);

    cyc("ind_r3",     3, 0, 0, 1, 0, 0, 0, 0, 1'b1, 32'h0);
    cyc("ind_issue",  6, 1, 4, 1, 1, 1, 0, 0, 1'b1, 32'h8);
    cyc("ind_set6",   0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h48);
    cyc("rawb_stall", 0, 0, 6, 0, 0, 1, 3, 1, 1'b0, 32'h48);
    cyc("rawb_byp",   0, 0, 6, 0, 0, 1, 6, 1, 1'b1, 32'h40);
    cyc("ind_clr",    0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0);

    cyc("sc_issue7",  7, 0, 0, 1, 0, 0, 0, 0, 1'b1, 32'h0);
    cyc("sc_same7",   7, 0, 0, 1, 0, 0, 7, 1, 1'b1, 32'h80);
    cyc("sc_diff",    8, 0, 0, 1, 0, 0, 7, 1, 1'b1, 32'h80);
    cyc("sc_after",   0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h100);

    cyc("inv_issue1", 1, 0, 0, 1, 0, 0, 0, 0, 1'b1, 32'h100);
    cyc("inv_flags",  1, 1, 1, 0, 0, 0, 0, 0, 1'b1, 32'h102);
    cyc("inv_vala",   0, 1, 0, 0, 1, 0, 0, 0, 1'b0, 32'h102);
    cyc("r0_issue",   0, 0, 0, 1, 0, 0, 0, 0, 1'b1, 32'h102);
    cyc("r0_stall",   0, 0, 0, 0, 0, 1, 0, 0, 1'b0, 32'h103);
    cyc("pre_rst",    0, 1, 0, 0, 1, 0, 0, 0, 1'b0, 32'h103);

    // Reset rises mid-cycle; the check lands before the next clock edge
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 1, 0, 0, 0);
    #1 rst = 1'b1;
    push("async_rst", 1'b1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1, 0, 0, 1, 0, 1, 1);
    push("post_rst", 1'b1, 32'h0);
    cyc("post_idle",  0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0);

    drv_done = 1;
  end

  initial begin : finisher
    int budget;
    budget = 2000;
    while (!(drv_done && sbq.size() == 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (budget == 0 || sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
